// File: rtl/tick_gen_pkg.sv
// Shared clock-rate constants and helpers for run-time tick generation.
// Replaces the fixed compile-time divider constants with enums and elaboration-time functions.
package tick_gen_pkg;

  localparam logic [63:0] CLK_FREQ      = 64'd100_000_000;
  localparam logic [63:0] RTC_FREQ      = 64'd32_768;
  localparam logic [63:0] UART_BAUD     = 64'd115_200;
  localparam int          ACC_WIDTH_DEF = 32;

  typedef enum logic {
    TICK_DIV  = 1'b0,
    TICK_FRAC = 1'b1
  } tick_mode_t;

  // Register layout of one channel at the default accumulator width.
  typedef struct packed {
    logic                     en;
    tick_mode_t               mode;
    logic [ACC_WIDTH_DEF-1:0] value;
  } tick_chan_reg_t;

  // Rounded phase increment: freq * 2^acc_width / CLK_FREQ, in 64-bit arithmetic.
  function automatic logic [63:0] frac_inc(input logic [63:0] freq,
                                           input int acc_width = ACC_WIDTH_DEF);
    logic [63:0] num;
    num = (freq << acc_width) + (CLK_FREQ >> 1);
    return num / CLK_FREQ;
  endfunction

  // Legacy integer divider semantics: (f/fo)/2-1.
  function automatic logic [63:0] tick_div(input logic [63:0] freq);
    return ((CLK_FREQ / freq) >> 1) - 64'd1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: configuration registers plus an integer-divide or
// fractional phase-accumulator counter, with registered tick/toggle outputs.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int                   ACC_WIDTH   = 32,
  parameter logic                 RESET_EN    = 1'b1,
  parameter tick_mode_t           RESET_MODE  = TICK_DIV,
  parameter logic [ACC_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 wr_enable,
  input  tick_mode_t           wr_mode,
  input  logic [ACC_WIDTH-1:0] wr_value,
  input  logic                 restart,
  output logic                 tick,
  output logic                 toggle,
  output logic [ACC_WIDTH-1:0] cfg_value
);

  logic                 en;
  tick_mode_t           mode;
  logic [ACC_WIDTH-1:0] value;
  logic [ACC_WIDTH-1:0] cnt;
  logic                 tick_q;
  logic                 tog_q;

  logic [ACC_WIDTH:0]   frac_sum;
  logic [ACC_WIDTH-1:0] cnt_nxt;
  logic                 tick_nxt;

  always_comb begin
    frac_sum = {1'b0, cnt} + {1'b0, value};
    cnt_nxt  = '0;
    tick_nxt = 1'b0;
    if (en) begin
      if (mode == TICK_FRAC) begin
        cnt_nxt  = frac_sum[ACC_WIDTH-1:0];
        tick_nxt = frac_sum[ACC_WIDTH];
      end else if (cnt == value) begin
        tick_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + ACC_WIDTH'(1);
      end
    end
  end

  // A write also clears the phase so the new configuration starts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      en     <= RESET_EN;
      mode   <= RESET_MODE;
      value  <= RESET_VALUE;
      cnt    <= '0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
    end else if (wr) begin
      en     <= wr_enable;
      mode   <= wr_mode;
      value  <= wr_value;
      cnt    <= '0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tick_q <= tick_nxt;
      tog_q  <= en & (tog_q ^ tick_nxt);
    end
  end

  assign tick      = tick_q;
  assign toggle    = tog_q;
  assign cfg_value = value;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick / clock-enable generator: write decode and output
// packing around CHANNELS independent tick_chan instances.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                                  CHANNELS    = 3,
  parameter int                                  ACC_WIDTH   = 32,
  parameter logic [CHANNELS-1:0]                 RESET_EN    = '1,
  parameter logic [CHANNELS-1:0]                 RESET_MODE  = 3'b100,
  parameter logic [CHANNELS-1:0][ACC_WIDTH-1:0]  RESET_VALUE =
    {ACC_WIDTH'(frac_inc(RTC_FREQ, ACC_WIDTH)), {ACC_WIDTH{1'b0}}, {ACC_WIDTH{1'b0}}},
  localparam int                                 CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [CW-1:0]                 wr_chan,
  input  logic                          wr_enable,
  input  logic                          wr_mode,
  input  logic [ACC_WIDTH-1:0]          wr_value,
  input  logic [CHANNELS-1:0]           restart,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           toggle,
  output logic [CHANNELS*ACC_WIDTH-1:0] cfg_value
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr_hit;

    // Indices at or above CHANNELS match no instance and are dropped.
    assign wr_hit = wr_en && (wr_chan == CW'(i));

    tick_chan #(
      .ACC_WIDTH   (ACC_WIDTH),
      .RESET_EN    (RESET_EN[i]),
      .RESET_MODE  (tick_mode_t'(RESET_MODE[i])),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .wr        (wr_hit),
      .wr_enable (wr_enable),
      .wr_mode   (tick_mode_t'(wr_mode)),
      .wr_value  (wr_value),
      .restart   (restart[i]),
      .tick      (tick[i]),
      .toggle    (toggle[i]),
      .cfg_value (cfg_value[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: reset defaults, UART divisor, RTC fractional
// rate, restart, write/restart collision, disable and out-of-range writes.
module tb_tick_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic        wr_enable;
  logic        wr_mode;
  logic [31:0] wr_value;
  logic [2:0]  restart;
  logic [2:0]  tick;
  logic [2:0]  toggle;
  logic [95:0] cfg_value;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  localparam logic [95:0] CFG_RESET = {32'd1407375, 32'd0, 32'd0};
  localparam logic [95:0] CFG_LATE  = {32'd1407375, 32'd3, 32'd0};

  tick_gen dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_chan   (wr_chan),
    .wr_enable (wr_enable),
    .wr_mode   (wr_mode),
    .wr_value  (wr_value),
    .restart   (restart),
    .tick      (tick),
    .toggle    (toggle),
    .cfg_value (cfg_value)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic en, input logic md,
                           input logic [31:0] v, input logic [2:0] rs, output int e);
    wr_en = 1'b1; wr_chan = ch; wr_enable = en; wr_mode = md; wr_value = v; restart = rs;
    step();
    e = cyc;
    wr_en = 1'b0; restart = 3'b000;
  endtask

  task automatic pulse_restart(input logic [2:0] rs, output int e);
    restart = rs;
    step();
    e = cyc;
    restart = 3'b000;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      step();
      if (tick[ch]) begin
        at = cyc;
        return;
      end
    end
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -2;
    return exp_q.pop_front();
  endfunction

  initial begin
    int e, at, r, ecol, last, nt, k;
    longint acc;

    reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_enable = 1'b0;
    wr_mode = 1'b0; wr_value = '0; restart = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tick", 128'(tick), 128'(0));
      check("rst_toggle", 128'(toggle), 128'(0));
      check("rst_cfg", 128'(cfg_value), 128'(CFG_RESET));
    end

    // Reset release: edge e was the last one sampling reset high.
    reset = 1'b0;
    e = cyc;
    acc = 0;
    for (int j = 1; j <= 31000; j++) begin
      acc += 64'd1407375;
      if (acc >= 64'h1_0000_0000) begin
        exp_q.push_back(e + j);
        acc -= 64'h1_0000_0000;
      end
    end
    last = 0; nt = 0;
    for (int j = 1; j <= 31000; j++) begin
      step();
      k = cyc - e;
      if (k <= 6) begin
        check("ch0_tick", 128'(tick[0]), 128'(1));
        check("ch0_toggle", 128'(toggle[0]), 128'(k % 2));
      end
      if (tick[2]) begin
        nt++;
        check("rtc_tick_at", 128'(cyc), 128'(pop_exp()));
        if (last > 0)
          check("rtc_spacing", 128'((cyc - last == 3051) || (cyc - last == 3052)), 128'(1));
        last = cyc;
      end
    end
    check("rtc_missing", 128'(exp_q.size()), 128'(0));
    check("rtc_count", 128'(nt), 128'(10));
    exp_q.delete();

    // UART divisor 433 on channel 1.
    cfg_write(2'd1, 1'b1, 1'b0, 32'd433, 3'b000, e);
    check("uart_cfg", 128'(cfg_value[63:32]), 128'(433));
    exp_q.push_back(e + 434);
    exp_q.push_back(e + 868);
    wait_tick(1, 500, at);
    check("uart_tick1", 128'(at), 128'(pop_exp()));
    check("uart_tog1", 128'(toggle[1]), 128'(1));
    wait_tick(1, 500, at);
    check("uart_tick2", 128'(at), 128'(pop_exp()));
    check("uart_tog2", 128'(toggle[1]), 128'(0));

    // Restart 4 cycles after a tick, DIV 9.
    cfg_write(2'd1, 1'b1, 1'b0, 32'd9, 3'b000, e);
    exp_q.push_back(e + 10);
    wait_tick(1, 20, at);
    check("rs_tick0", 128'(at), 128'(pop_exp()));
    check("rs_tog0", 128'(toggle[1]), 128'(1));
    for (int j = 0; j < 3; j++) step();
    pulse_restart(3'b010, r);
    check("rs_at_edge", 128'(r - at), 128'(4));
    check("rs_tog_clr", 128'(toggle[1]), 128'(0));
    check("rs_tick_clr", 128'(tick[1]), 128'(0));
    exp_q.push_back(r + 10);
    wait_tick(1, 20, at);
    check("rs_tick1", 128'(at), 128'(pop_exp()));
    check("rs_tog1", 128'(toggle[1]), 128'(1));

    // Write ch1 DIV 3 together with restart of ch0 and ch1.
    cfg_write(2'd1, 1'b1, 1'b0, 32'd3, 3'b011, ecol);
    check("col_cfg", 128'(cfg_value[63:32]), 128'(3));
    check("col_ch0_tick", 128'(tick[0]), 128'(0));
    check("col_ch0_tog", 128'(toggle[0]), 128'(0));
    check("col_ch1_tick", 128'(tick[1]), 128'(0));
    step();
    check("col_ch0_tick1", 128'(tick[0]), 128'(1));
    check("col_ch0_tog1", 128'(toggle[0]), 128'(1));
    exp_q.push_back(ecol + 4);
    wait_tick(1, 10, at);
    check("col_ch1_at", 128'(at), 128'(pop_exp()));

    // Disable channel 2.
    cfg_write(2'd2, 1'b0, 1'b1, 32'd1407375, 3'b000, e);
    for (int j = 0; j < 100; j++) begin
      step();
      check("dis_ch2", 128'({tick[2], toggle[2]}), 128'(0));
    end

    // Out-of-range channel index leaves every channel untouched.
    cfg_write(2'd3, 1'b1, 1'b0, 32'd5, 3'b000, e);
    check("oor_cfg", 128'(cfg_value), 128'(CFG_LATE));
    check("oor_ch0", 128'(tick[0]), 128'(1));
    check("oor_ch2", 128'({tick[2], toggle[2]}), 128'(0));
    wait_tick(1, 10, at);
    check("oor_ch1_phase", 128'((at > 0) && ((at - ecol) % 4 == 0)), 128'(1));

    // Reset mid-period drops everything at once.
    reset = 1'b1;
    step();
    check("rst2_tick", 128'(tick), 128'(0));
    check("rst2_toggle", 128'(toggle), 128'(0));
    check("rst2_cfg", 128'(cfg_value), 128'(CFG_RESET));
    reset = 1'b0;
    step();
    check("rst2_ch0", 128'(tick[0]), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel tick and clock-enable generator: the run-time successor to the fixed compile-time divider constants (PLL enable, RTC tick, UART bit rate) in the `configure` package. Each channel produces a one-cycle `tick` pulse and a 50 % `toggle` signal from the system clock. A channel runs in one of two modes:
- integer-divide mode, which keeps the existing `(f/fo)/2-1` divider semantics;
- fractional phase-accumulator mode, for rates such as 32768 Hz that do not divide `clk_freq`.

It sits beside the CLINT/UART peripherals and feeds their enables. Channels can be reprogrammed and phase-restarted at run time.

## Interface
- `CHANNELS`, default 3: number of independent channels.
- `ACC_WIDTH`, default 32: counter/accumulator and config value width.
- `RESET_EN`, `[CHANNELS-1:0]`, default all 1: per-channel enable after reset.
- `RESET_MODE`, `[CHANNELS-1:0]`, default `3'b100`: per-channel mode after reset; 0 = DIV, 1 = FRAC.
- `RESET_VALUE`, `[CHANNELS-1:0][ACC_WIDTH-1:0]`, default `{frac_inc(rtc_freq), 0, 0}`: per-channel divisor or increment after reset.
- `clock` in 1: single system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: configuration write strobe, single cycle, always accepted.
- `wr_chan` in `$clog2(CHANNELS)` (min 1): target channel. Indices ≥ `CHANNELS` are ignored.
- `wr_enable` in 1: new enable for the target channel.
- `wr_mode` in 1: new mode for the target channel.
- `wr_value` in `ACC_WIDTH`: new divisor (DIV) or increment (FRAC).
- `restart` in `CHANNELS`: per-channel phase restart.
- `tick` out `CHANNELS`: registered one-cycle pulse per period.
- `toggle` out `CHANNELS`: registered square wave that flips on every tick.
- `cfg_value` out `CHANNELS*ACC_WIDTH`: current per-channel value, for read-back.

## Operation
- Per-channel state: `en`, `mode`, `value`, `cnt` (ACC_WIDTH bits), `tick_q`, `tog_q`.
- **Reset:**
  - `en`, `mode`, `value` load the `RESET_*` parameters.
  - `cnt` = 0, `tick` = 0, `toggle` = 0.
  - `cfg_value` = `RESET_VALUE`.
- **DIV mode:**
  - If `cnt == value`: `cnt` ← 0, `tick_q` ← 1, `tog_q` flips.
  - Otherwise: `cnt` ← `cnt + 1`, `tick_q` ← 0.
  - Tick period is `value + 1` cycles; toggle period is `2*(value + 1)`.
  - `value` = 0 gives a tick every cycle and a toggle at `clk/2`.
- **FRAC mode:**
  - `{carry, cnt}` ← `cnt + value`, computed in ACC_WIDTH+1 bits.
  - `tick_q` ← carry; `tog_q` flips on carry.
  - Average tick rate is `clock_freq * value / 2^ACC_WIDTH`.
  - `value` = 0 never ticks.
- **Disabled channel** (`en` = 0): `cnt` held at 0, `tick` = 0, `toggle` = 0.
- **Write** (`wr_en`, valid `wr_chan`):
  - `en`, `mode`, `value` update at the edge.
  - `cnt`, `tick_q`, `tog_q` clear at the same edge, so the new configuration starts from phase 0.
- **restart[i]:** clears `cnt`, `tick_q`, `tog_q` of channel i. Configuration is kept.
- **Priority, highest first:** `reset` > write > `restart` > count.
  - A write and a restart to the same channel in the same cycle behave as a write.
  - A write to channel j and a restart of channel k ≠ j both take effect.
- **Reset mid-period:** reset drops any pending tick. `tick` is 0 in the cycle after reset is sampled.

## Timing
- `tick` and `toggle` are register outputs, with no combinational path from any input.
- Latency is counted from the configuration edge E (reset release, write, or restart).
  - DIV, value V: `tick` is high in cycle `E+V+1`, then every `V+1` cycles.
  - FRAC, increment I: first tick when `k*I ≥ 2^ACC_WIDTH`, i.e. high in cycle `E+k`.
- `cfg_value` updates one cycle after the write.
- Channels are fully independent; ticks on different channels may coincide.

## Structure
- Shared `configure` package gains:
  - `tick_mode_t` enum (`TICK_DIV`, `TICK_FRAC`).
  - `tick_chan_reg_t` struct (`en`, `mode`, `value`).
  - Elaboration-time function `frac_inc(freq)` = `round(freq * 2^ACC_WIDTH / clk_freq)`, computed in 64-bit.
  - Constant `tick_div(freq)` = `(clk_freq/freq)/2-1`.
- Sub-module `tick_chan`: one channel's state and counter, instantiated `CHANNELS` times in a generate loop. The top level does write decode and output packing only.

## Test plan
- **Reset defaults:** hold `reset` 3 cycles, then release. Channel 0 (DIV, 0) gives `tick` = 1 every cycle and `toggle` alternating 0/1 from cycle E+1. All outputs are 0 during reset.
- **UART divisor:** write channel 1 DIV `value` = 433. Ticks appear at E+434, E+868; `toggle` period is 868 cycles.
- **RTC fractional, channel 2:** `RESET_VALUE` = 1407375 (32768 Hz at 100 MHz, ACC_WIDTH 32). Expect exactly 327 ticks in 1,000,000 cycles after reset release, with spacing of 3051 or 3052 cycles only.
- **Restart mid-period:** DIV 9. Assert `restart` 4 cycles after a tick. The next tick comes 10 cycles after the restart edge; `toggle` is forced to 0 at the restart.
- **Write/restart collision:** in the same cycle, write channel 1 DIV 3 and pulse `restart` on channels 1 and 0. Channel 1 ticks at E+4; channel 0 restarts; `cfg_value[1]` = 3 on the next cycle.
- **Disable and out-of-range write:**
  - Write `wr_enable` = 0 to channel 2: its `tick` and `toggle` stay 0 for 100 cycles.
  - Write `wr_chan` = 3: all channels unchanged.
